// File: rtl/instruction_fetch.sv
// Instruction fetch: reads one- or two-byte instructions from an 8-bit program memory
// and holds each one for the execute stage until it is consumed or a redirect occurs.
//
// state  | meaning
// FETCH1 | read opcode byte at pc, classify length
// FETCH2 | read operand byte at pc (two-byte instructions only)
// HOLD   | instruction valid, waiting for instr_ready
module instruction_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] address_bus,
    input  logic [7:0] data_bus,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] opcode,
    output logic [7:0] operand,
    output logic       instr_len2,
    output logic [7:0] instr_pc,
    input  logic       redirect,
    input  logic [7:0] redirect_addr
);

    typedef enum logic [1:0] {
        FETCH1 = 2'd0,
        FETCH2 = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t     state_q;
    logic [7:0] pc_q;
    logic [7:0] opcode_q;
    logic [7:0] operand_q;
    logic [7:0] instr_pc_q;
    logic       valid_q;
    logic       len2_q;

    logic [7:0] pc_inc;
    logic       is_two;

    // 8-bit wrap is intentional: an instruction at FF takes its operand from 00
    assign pc_inc = pc_q + 8'd1;

    // LD_IMM, CMP_IMM, BRA, BHI, BEQ carry an immediate/target byte
    always_comb begin
        is_two = 1'b0;
        case (data_bus[7:2])
            6'b100000, 6'b100011, 6'b101010, 6'b101100, 6'b101101: is_two = 1'b1;
            default: is_two = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH1;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            opcode_q   <= 8'h70;
            operand_q  <= 8'h00;
            len2_q     <= 1'b0;
            instr_pc_q <= 8'h00;
        end else if (redirect) begin
            // a redirect in HOLD also retires the held instruction
            state_q <= FETCH1;
            pc_q    <= redirect_addr;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH1: begin
                    opcode_q   <= data_bus;
                    instr_pc_q <= pc_q;
                    operand_q  <= 8'h00;
                    len2_q     <= is_two;
                    pc_q       <= pc_inc;
                    if (is_two) begin
                        state_q <= FETCH2;
                    end else begin
                        state_q <= HOLD;
                        valid_q <= 1'b1;
                    end
                end
                FETCH2: begin
                    operand_q <= data_bus;
                    pc_q      <= pc_inc;
                    state_q   <= HOLD;
                    valid_q   <= 1'b1;
                end
                HOLD: begin
                    if (instr_ready) begin
                        state_q <= FETCH1;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= FETCH1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign address_bus = pc_q;
    assign instr_valid = valid_q;
    assign opcode      = opcode_q;
    assign operand     = operand_q;
    assign instr_len2  = len2_q;
    assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, a RESET_PC=FF wrap sequence,
// and randomized traffic checked against a transaction-level model.
module tb_instruction_fetch;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];

    logic       reset, instr_ready, redirect;
    logic [7:0] redirect_addr;
    logic [7:0] address_bus, data_bus, opcode, operand, instr_pc;
    logic       instr_valid, instr_len2;

    logic       reset1, ready1, redirect1;
    logic [7:0] raddr1;
    logic [7:0] addr1, data1, opcode1, operand1, ipc1;
    logic       valid1, len2_1;

    assign data_bus = mem0[address_bus];
    assign data1    = mem1[addr1];

    instruction_fetch #(.RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset), .address_bus(address_bus), .data_bus(data_bus),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .opcode(opcode),
        .operand(operand), .instr_len2(instr_len2), .instr_pc(instr_pc),
        .redirect(redirect), .redirect_addr(redirect_addr)
    );

    instruction_fetch #(.RESET_PC(8'hFF)) dut_ff (
        .clk(clk), .reset(reset1), .address_bus(addr1), .data_bus(data1),
        .instr_valid(valid1), .instr_ready(ready1), .opcode(opcode1),
        .operand(operand1), .instr_len2(len2_1), .instr_pc(ipc1),
        .redirect(redirect1), .redirect_addr(raddr1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic two_byte(input logic [7:0] b);
        logic [5:0] hi;
        hi = b[7:2];
        return (hi == 6'b100000) || (hi == 6'b100011) || (hi == 6'b101010) ||
               (hi == 6'b101100) || (hi == 6'b101101);
    endfunction

    typedef struct {
        logic       rst, rdy, redir;
        logic [7:0] raddr;
        logic       full;
        logic       valid;
        logic [7:0] addr, opc, opr;
        logic       len2;
        logic [7:0] ipc;
    } vec_t;

    function automatic vec_t v(input logic rst, input logic rdy, input logic redir,
                               input logic [7:0] ra, input logic full, input logic val,
                               input logic [7:0] addr, input logic [7:0] opc,
                               input logic [7:0] opr, input logic l2, input logic [7:0] ipc);
        vec_t r;
        r.rst = rst; r.rdy = rdy; r.redir = redir; r.raddr = ra; r.full = full;
        r.valid = val; r.addr = addr; r.opc = opc; r.opr = opr; r.len2 = l2; r.ipc = ipc;
        return r;
    endfunction

    vec_t vt [22];

    // transaction-level reference: address of the instruction being fetched, cycles
    // spent on it, and the instruction currently offered to execute
    logic [7:0] m_fp, m_opc, m_opr, m_ipc;
    int         m_cyc;
    logic       m_valid, m_len;

    task automatic model_edge(input logic rst, input logic rdy, input logic redir,
                              input logic [7:0] ra);
        logic [7:0] nxt;
        if (rst) begin
            m_fp = 8'h00; m_cyc = 0; m_valid = 1'b0;
            m_opc = 8'h70; m_opr = 8'h00; m_len = 1'b0; m_ipc = 8'h00;
        end else if (redir) begin
            m_fp = ra; m_cyc = 0; m_valid = 1'b0;
        end else if (m_valid) begin
            if (rdy) begin
                m_valid = 1'b0;
                m_fp = m_ipc + 8'd1 + {7'd0, m_len};
                m_cyc = 0;
            end
        end else begin
            m_cyc++;
            if (m_cyc == (two_byte(mem0[m_fp]) ? 2 : 1)) begin
                nxt     = m_fp + 8'd1;
                m_valid = 1'b1;
                m_opc   = mem0[m_fp];
                m_len   = two_byte(mem0[m_fp]);
                m_opr   = m_len ? mem0[nxt] : 8'h00;
                m_ipc   = m_fp;
            end
        end
    endtask

    function automatic logic [7:0] model_addr();
        if (m_valid) return m_ipc + 8'd1 + {7'd0, m_len};
        return m_fp + 8'(m_cyc);
    endfunction

    initial begin
        reset = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_addr = 8'h00;
        reset1 = 1'b1; ready1 = 1'b1; redirect1 = 1'b0; raddr1 = 8'h00;

        for (int i = 0; i < 256; i++) begin
            mem0[i] = 8'h70;
            mem1[i] = 8'h70;
        end
        mem0[8'h00] = 8'h98; mem0[8'h01] = 8'h99; mem0[8'h02] = 8'h01;
        mem0[8'h03] = 8'hA8; mem0[8'h04] = 8'h05; mem0[8'h05] = 8'h80;
        mem0[8'h06] = 8'h11; mem0[8'h20] = 8'h3C;
        mem1[8'hFF] = 8'h80; mem1[8'h00] = 8'h3C;

        vt[0]  = v(1, 0, 0, 8'h00, 1, 0, 8'h00, 8'h70, 8'h00, 0, 8'h00);
        vt[1]  = v(0, 1, 0, 8'h00, 1, 1, 8'h01, 8'h98, 8'h00, 0, 8'h00);
        vt[2]  = v(0, 1, 0, 8'h00, 0, 0, 8'h01, 8'h00, 8'h00, 0, 8'h00);
        vt[3]  = v(0, 1, 0, 8'h00, 1, 1, 8'h02, 8'h99, 8'h00, 0, 8'h01);
        vt[4]  = v(0, 1, 0, 8'h00, 0, 0, 8'h02, 8'h00, 8'h00, 0, 8'h00);
        vt[5]  = v(0, 1, 0, 8'h00, 1, 1, 8'h03, 8'h01, 8'h00, 0, 8'h02);
        vt[6]  = v(0, 1, 0, 8'h00, 0, 0, 8'h03, 8'h00, 8'h00, 0, 8'h00);
        vt[7]  = v(0, 1, 0, 8'h00, 0, 0, 8'h04, 8'h00, 8'h00, 0, 8'h00);
        vt[8]  = v(0, 1, 0, 8'h00, 1, 1, 8'h05, 8'hA8, 8'h05, 1, 8'h03);
        for (int i = 9; i <= 13; i++)
            vt[i] = v(0, 0, 0, 8'h00, 1, 1, 8'h05, 8'hA8, 8'h05, 1, 8'h03);
        vt[14] = v(0, 1, 0, 8'h00, 0, 0, 8'h05, 8'h00, 8'h00, 0, 8'h00);
        vt[15] = v(0, 1, 0, 8'h00, 0, 0, 8'h06, 8'h00, 8'h00, 0, 8'h00);
        vt[16] = v(0, 1, 1, 8'h20, 0, 0, 8'h20, 8'h00, 8'h00, 0, 8'h00);
        vt[17] = v(0, 0, 0, 8'h00, 1, 1, 8'h21, 8'h3C, 8'h00, 0, 8'h20);
        vt[18] = v(0, 1, 1, 8'h20, 0, 0, 8'h20, 8'h00, 8'h00, 0, 8'h00);
        vt[19] = v(0, 0, 0, 8'h00, 1, 1, 8'h21, 8'h3C, 8'h00, 0, 8'h20);
        vt[20] = v(1, 1, 1, 8'h55, 1, 0, 8'h00, 8'h70, 8'h00, 0, 8'h00);
        vt[21] = v(0, 1, 0, 8'h00, 1, 1, 8'h01, 8'h98, 8'h00, 0, 8'h00);

        // RESET_PC = FF: two-byte instruction wraps for its operand
        step();
        chk("ff reset addr", addr1, 8'hFF);
        chk("ff reset valid", {7'd0, valid1}, 8'h00);
        chk("ff reset opcode", opcode1, 8'h70);
        reset1 = 1'b0;
        step();
        chk("ff fetch1 addr", addr1, 8'h00);
        chk("ff fetch1 valid", {7'd0, valid1}, 8'h00);
        step();
        chk("ff valid", {7'd0, valid1}, 8'h01);
        chk("ff opcode", opcode1, 8'h80);
        chk("ff operand", operand1, 8'h3C);
        chk("ff instr_pc", ipc1, 8'hFF);
        chk("ff len2", {7'd0, len2_1}, 8'h01);
        chk("ff next addr", addr1, 8'h01);
        step();
        chk("ff handshake valid", {7'd0, valid1}, 8'h00);
        chk("ff handshake addr", addr1, 8'h01);
        reset1 = 1'b1;

        for (int i = 0; i < 22; i++) begin
            reset = vt[i].rst; instr_ready = vt[i].rdy;
            redirect = vt[i].redir; redirect_addr = vt[i].raddr;
            step();
            chk($sformatf("vec%0d valid", i), {7'd0, instr_valid}, {7'd0, vt[i].valid});
            chk($sformatf("vec%0d addr", i), address_bus, vt[i].addr);
            if (vt[i].full) begin
                chk($sformatf("vec%0d opcode", i), opcode, vt[i].opc);
                chk($sformatf("vec%0d operand", i), operand, vt[i].opr);
                chk($sformatf("vec%0d len2", i), {7'd0, instr_len2}, {7'd0, vt[i].len2});
                chk($sformatf("vec%0d instr_pc", i), instr_pc, vt[i].ipc);
            end
        end

        // random program, random handshake / redirect / reset traffic
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 4))
                    0: mem0[i] = {6'b100000, 2'($urandom)};
                    1: mem0[i] = {6'b100011, 2'($urandom)};
                    2: mem0[i] = {6'b101010, 2'($urandom)};
                    3: mem0[i] = {6'b101100, 2'($urandom)};
                    default: mem0[i] = {6'b101101, 2'($urandom)};
                endcase
            end else begin
                mem0[i] = 8'($urandom);
            end
        end
        reset = 1'b1; instr_ready = 1'b0; redirect = 1'b0;
        step();
        model_edge(1'b1, 1'b0, 1'b0, 8'h00);
        for (int c = 0; c < 3000; c++) begin
            reset         = ($urandom_range(0, 99) == 0);
            instr_ready   = ($urandom_range(0, 9) < 6);
            redirect      = ($urandom_range(0, 19) == 0);
            redirect_addr = 8'($urandom);
            step();
            model_edge(reset, instr_ready, redirect, redirect_addr);
            chk($sformatf("rnd%0d valid", c), {7'd0, instr_valid}, {7'd0, m_valid});
            chk($sformatf("rnd%0d addr", c), address_bus, model_addr());
            if (m_valid) begin
                chk($sformatf("rnd%0d opcode", c), opcode, m_opc);
                chk($sformatf("rnd%0d operand", c), operand, m_opr);
                chk($sformatf("rnd%0d len2", c), {7'd0, instr_len2}, {7'd0, m_len});
                chk($sformatf("rnd%0d instr_pc", c), instr_pc, m_ipc);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_PC, default 8'h00, address of the first opcode fetched after reset.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 address_bus  output  8  byte address presented to program memory.
REQ-005 data_bus  input  8  program memory read data; combinational from address_bus, valid in the same cycle.
REQ-006 instr_valid  output  1  held instruction is valid for the execute stage.
REQ-007 instr_ready  input  1  execute stage consumes the held instruction this cycle.
REQ-008 opcode  output  8  first instruction byte.
REQ-009 operand  output  8  second byte for two-byte instructions; 8'h00 otherwise.
REQ-010 instr_len2  output  1  held instruction is two bytes.
REQ-011 instr_pc  output  8  address of the held instruction's opcode byte.
REQ-012 redirect  input  1  branch taken; fetch restarts at redirect_addr.
REQ-013 redirect_addr  input  8  branch target address.

Function
REQ-014 The block SHALL be a three-state FSM: FETCH1, FETCH2, HOLD; address_bus SHALL equal pc in every state.
REQ-015 Two-byte classification SHALL be opcode[7:2] in {100000 LD_IMM, 100011 CMP_IMM, 101010 BRA, 101100 BHI, 101101 BEQ}; all other bytes are one-byte instructions.
REQ-016 FETCH1: latch opcode<=data_bus, instr_pc<=pc, operand<=8'h00, pc<=pc+1; go to FETCH2 if two-byte, else HOLD.
REQ-017 FETCH2: operand<=data_bus, pc<=pc+1, go to HOLD.
REQ-018 HOLD: instr_valid=1, outputs stable; on instr_ready=1 go to FETCH1 next cycle; otherwise remain in HOLD (back-pressure, no fetch).
REQ-019 instr_valid SHALL be 1 only in HOLD; the handshake completes on the cycle where instr_valid and instr_ready are both 1.
REQ-020 Latency: a one-byte instruction SHALL be valid 1 cycle after its FETCH1 cycle; a two-byte instruction 2 cycles after; throughput is one instruction per 2 cycles (one-byte) or 3 cycles (two-byte) with instr_ready held high.
REQ-021 pc arithmetic SHALL be 8-bit modulo 256: 8'hFF+1 = 8'h00; a two-byte instruction at 8'hFF SHALL take its operand from 8'h00.
REQ-022 redirect=1 in any state SHALL set pc<=redirect_addr, state<=FETCH1, instr_valid 0 next cycle; any partially fetched instruction is discarded.
REQ-023 redirect together with instr_ready in HOLD: redirect wins; the held instruction counts as consumed; the next fetch is from redirect_addr.
REQ-024 instr_ready while not in HOLD SHALL be ignored.

Reset
REQ-025 reset=1 on a clock edge SHALL set pc=RESET_PC, state=FETCH1, instr_valid=0, opcode=8'h70 (NOP), operand=8'h00, instr_len2=0, instr_pc=8'h00.
REQ-026 reset SHALL take priority over redirect and instr_ready, and SHALL abort a fetch in progress in any state.
REQ-027 The first FETCH1 SHALL occur in the first cycle with reset=0.

Verification
REQ-028 Memory {0:98, 1:99, 2:01, 3:9C}, instr_ready=1, reset released -> valid opcode 98 instr_pc 00 len2 0; then 99 at 01; then 01 at 02; instr_valid high every 2nd cycle.
REQ-029 Memory {0:A8, 1:05}, instr_ready=1 -> opcode A8, operand 05, instr_len2 1, instr_pc 00 valid 2 cycles after FETCH1; next fetch from address 02.
REQ-030 instr_ready=0 for 5 cycles in HOLD -> outputs stable, address_bus constant, no new fetch; instr_ready=1 -> FETCH1 at next address following cycle.
REQ-031 RESET_PC=8'hFF, memory {FF:80, 00:3C} -> opcode 80, operand 3C, instr_pc FF, next fetch address 01.
REQ-032 redirect=1, redirect_addr=8'h20 asserted during FETCH2 of a two-byte instruction -> no instr_valid for it; next FETCH1 address 20; same with redirect+instr_ready in HOLD -> next fetch 20.
REQ-033 reset=1 asserted in HOLD with instr_valid=1 -> next cycle instr_valid 0, opcode 70, operand 00, address_bus RESET_PC.
